// File: rtl/psum_requant_pack.sv
// Requantizes eight signed 32-bit partial sums to int8 and packs them into a
// 64-bit word. The word leaves through a ready/valid FIFO and carries a tile-end tag.
module psum_requant_pack #(
  parameter int LANES      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [LANES*32-1:0]   i_psum,
  output logic                  i_ready,
  input  logic [15:0]           cfg_scale,
  input  logic [4:0]            cfg_shift,
  input  logic [7:0]            cfg_zp,
  input  logic                  cfg_relu,
  input  logic [15:0]           cfg_len,
  output logic [LANES*8-1:0]    o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = LANES * 8;

  logic          accept;
  logic          rd_fire;
  logic [CW-1:0] occ_q, occ_d;

  logic          s1_valid_q;
  logic          s2_valid_q;
  logic [DW-1:0] s2_word_d, s2_word_q;

  logic [DW:0]   mem_q [FIFO_DEPTH];
  logic [CW-1:0] wptr_q, rptr_q;
  logic          fifo_empty;
  logic [DW:0]   head;

  logic [15:0]   wcnt_q, wcnt_d;
  logic [15:0]   len_m1;
  logic          wr_last;

  // occ covers pipeline stages plus FIFO entries, so the FIFO cannot overflow
  // and the pipeline never needs to stall.
  assign accept  = i_valid && i_ready;
  assign rd_fire = o_valid && o_ready;
  assign i_ready = (occ_q < CW'(FIFO_DEPTH));
  assign o_busy  = (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    case ({accept, rd_fire})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [31:0] psum_lane;
      logic signed [48:0] prod_q;
      logic signed [63:0] ext, rnd, r, v, zp_ext, lo;
      logic        [7:0]  q;

      assign psum_lane = i_psum[gi*32 +: 32];

      always_ff @(posedge clk) begin
        if (accept) begin
          prod_q <= psum_lane * $signed({1'b0, cfg_scale});
        end
      end

      // 64-bit intermediates leave ample headroom above the 49-bit product.
      always_comb begin
        ext    = {{15{prod_q[48]}}, prod_q};
        zp_ext = {{56{cfg_zp[7]}}, cfg_zp};
        rnd    = (cfg_shift == 5'd0) ? 64'sd0 : (64'sd1 <<< (cfg_shift - 5'd1));
        r      = (ext + rnd) >>> cfg_shift;
        v      = r + zp_ext;
        lo     = cfg_relu ? zp_ext : -64'sd128;
        if (v > 64'sd127) begin
          q = 8'h7f;
        end else if (v < lo) begin
          q = lo[7:0];
        end else begin
          q = v[7:0];
        end
      end

      assign s2_word_d[gi*8 +: 8] = q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      s2_word_q <= s2_word_d;
    end
  end

  assign len_m1  = (cfg_len == 16'd0) ? 16'd0 : cfg_len - 16'd1;
  assign wr_last = (wcnt_q == len_m1);

  always_comb begin
    wcnt_d = wcnt_q;
    if (s2_valid_q) begin
      wcnt_d = wr_last ? 16'd0 : wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (s2_valid_q) begin
      mem_q[wptr_q[AW-1:0]] <= {wr_last, s2_word_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wcnt_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      wcnt_q     <= wcnt_d;
      if (s2_valid_q) begin
        wptr_q <= wptr_q + CW'(1);
      end
      if (rd_fire) begin
        rptr_q <= rptr_q + CW'(1);
      end
    end
  end

  // Head is gated so the outputs read zero while the FIFO is empty.
  assign fifo_empty = (wptr_q == rptr_q);
  assign head       = mem_q[rptr_q[AW-1:0]];
  assign o_valid    = !fifo_empty;
  assign o_data     = o_valid ? head[DW-1:0] : '0;
  assign o_last     = o_valid & head[DW];

endmodule
